// File: rtl/risc_pkg.sv
// Shared definitions for the multi-cycle RISC core: opcodes, FSM states, field widths.
package risc_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_NOP  = 4'd0;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'd1;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'd2;
  localparam logic [OPC_W-1:0] OP_AND  = 4'd3;
  localparam logic [OPC_W-1:0] OP_NOT  = 4'd4;
  localparam logic [OPC_W-1:0] OP_RD   = 4'd5;
  localparam logic [OPC_W-1:0] OP_WR   = 4'd6;
  localparam logic [OPC_W-1:0] OP_BR   = 4'd7;
  localparam logic [OPC_W-1:0] OP_BRZ  = 4'd8;
  localparam logic [OPC_W-1:0] OP_HALT = 4'd9;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_FETCH2 = 3'd3,
    S_RD     = 3'd4,
    S_WR     = 3'd5,
    S_BRANCH = 3'd6,
    S_HALT   = 3'd7
  } state_t;

endpackage

// File: rtl/risc_regfile.sv
// General register file: two asynchronous read ports, one synchronous write port.
module risc_regfile #(
  parameter int WORD_SIZE = 16,
  parameter int REG_COUNT = 8,
  parameter int RW        = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [RW-1:0]        waddr,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic [RW-1:0]        raddr_a,
  input  logic [RW-1:0]        raddr_b,
  output logic [WORD_SIZE-1:0] rdata_a,
  output logic [WORD_SIZE-1:0] rdata_b
);

  logic [WORD_SIZE-1:0] regs [REG_COUNT];

  // Register storage: cleared by reset, one write per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/risc_core_mc.sv
// Multi-cycle RISC core with a req/ready memory port, HALT/run control and an
// illegal-opcode flag. ALU, PC/IR/AR, Z flag and control FSM live here.
// Memory handshake: mem_req is registered and raised on entry to an access state;
// mem_addr/mem_we/mem_wdata stay constant while mem_req is high; an access completes
// in the cycle where mem_req & mem_ready, and mem_rdata is sampled in that cycle.
module risc_core_mc
  import risc_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int REG_COUNT = 8,
  parameter int ADDR_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ready,
  output logic                 halted,
  output logic                 illegal,
  output logic [ADDR_SIZE-1:0] pc_out
);

  localparam int RW = $clog2(REG_COUNT);
  localparam logic [ADDR_SIZE-1:0] PC_ONE = ADDR_SIZE'(1);

  state_t               state;
  logic [WORD_SIZE-1:0] ir;
  logic [ADDR_SIZE-1:0] pc;
  logic [ADDR_SIZE-1:0] ar;
  logic                 z;

  logic [OPC_W-1:0]     opcode;
  logic [RW-1:0]        src;
  logic [RW-1:0]        dst;
  logic                 unused_ir;

  logic [WORD_SIZE-1:0] rs_val;
  logic [WORD_SIZE-1:0] rd_val;
  logic [WORD_SIZE-1:0] alu_res;
  logic                 rf_we;
  logic [WORD_SIZE-1:0] rf_wdata;
  logic                 done;
  logic [ADDR_SIZE-1:0] pc_inc;
  logic [ADDR_SIZE-1:0] rdata_addr;

  // Instruction fields; bits below the dest field are don't-care.
  assign opcode    = ir[WORD_SIZE-1 -: OPC_W];
  assign src       = ir[WORD_SIZE-OPC_W-1 -: RW];
  assign dst       = ir[WORD_SIZE-OPC_W-RW-1 -: RW];
  assign unused_ir = ^ir;

  assign done       = mem_req & mem_ready;
  assign pc_inc     = pc + PC_ONE;
  assign rdata_addr = mem_rdata[ADDR_SIZE-1:0];
  assign pc_out     = pc;

  risc_regfile #(
    .WORD_SIZE (WORD_SIZE),
    .REG_COUNT (REG_COUNT),
    .RW        (RW)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (dst),
    .wdata   (rf_wdata),
    .raddr_a (src),
    .raddr_b (dst),
    .rdata_a (rs_val),
    .rdata_b (rd_val)
  );

  // ALU: modulo-2^WORD_SIZE arithmetic, carry/borrow dropped.
  always_comb begin
    alu_res = '0;
    case (opcode)
      OP_ADD:  alu_res = rd_val + rs_val;
      OP_SUB:  alu_res = rd_val - rs_val;
      OP_AND:  alu_res = rd_val & rs_val;
      OP_NOT:  alu_res = ~rs_val;
      default: alu_res = '0;
    endcase
  end

  // Register write-back: ALU result in EXEC, memory data when a RD completes.
  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = alu_res;
    if (state == S_EXEC) begin
      rf_we = 1'b1;
    end else if (state == S_RD && done) begin
      rf_we    = 1'b1;
      rf_wdata = mem_rdata;
    end
  end

  // Control FSM with registered memory request, PC/IR/AR, Z and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_FETCH;
      ir        <= '0;
      pc        <= '0;
      ar        <= '0;
      z         <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (done) begin
            ir      <= mem_rdata;
            pc      <= pc_inc;
            mem_req <= 1'b0;
            state   <= S_DECODE;
          end else if (!mem_req) begin
            // First fetch after reset: no access was raised on entry.
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_NOT: state <= S_EXEC;
            OP_RD, OP_WR, OP_BR, OP_BRZ: begin
              state    <= S_FETCH2;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= pc;
            end
            OP_HALT: begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
            OP_NOP: begin
              state    <= S_FETCH;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= pc;
            end
            default: begin
              illegal  <= 1'b1;
              state    <= S_FETCH;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= pc;
            end
          endcase
        end
        S_EXEC: begin
          z        <= (alu_res == '0);
          state    <= S_FETCH;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= pc;
        end
        S_FETCH2: begin
          if (done) begin
            ar <= rdata_addr;
            pc <= pc_inc;
            case (opcode)
              OP_RD: begin
                state    <= S_RD;
                mem_we   <= 1'b0;
                mem_addr <= rdata_addr;
              end
              OP_WR: begin
                state     <= S_WR;
                mem_we    <= 1'b1;
                mem_addr  <= rdata_addr;
                mem_wdata <= rs_val;
              end
              OP_BR: begin
                state   <= S_BRANCH;
                mem_req <= 1'b0;
              end
              default: begin
                if (opcode == OP_BRZ && z) begin
                  state   <= S_BRANCH;
                  mem_req <= 1'b0;
                end else begin
                  state    <= S_FETCH;
                  mem_we   <= 1'b0;
                  mem_addr <= pc_inc;
                end
              end
            endcase
          end
        end
        S_RD: begin
          if (done) begin
            state    <= S_FETCH;
            mem_addr <= pc;
          end
        end
        S_WR: begin
          if (done) begin
            state    <= S_FETCH;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end
        end
        S_BRANCH: begin
          pc       <= ar;
          state    <= S_FETCH;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= ar;
        end
        S_HALT: begin
          if (run) begin
            halted   <= 1'b0;
            state    <= S_FETCH;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_risc_core_mc.sv
// Directed bench for risc_core_mc: a 16-bit core with a wait-state memory model
// and a 32-bit/4-register core with a zero-wait memory.
module tb_risc_core_mc;
  import risc_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic run = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A (16-bit, 8 regs) ----------------
  logic        mem_req_a, mem_we_a, mem_ready_a, halted_a, illegal_a;
  logic [15:0] mem_addr_a, mem_wdata_a, mem_rdata_a, pc_a;

  risc_core_mc #(.WORD_SIZE(16), .REG_COUNT(8), .ADDR_SIZE(16)) u_dut_a (
    .clk(clk), .rst(rst), .run(run),
    .mem_req(mem_req_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a), .mem_ready(mem_ready_a),
    .halted(halted_a), .illegal(illegal_a), .pc_out(pc_a)
  );

  // ---------------- DUT B (32-bit, 4 regs) ----------------
  logic        mem_req_b, mem_we_b, mem_ready_b, halted_b, illegal_b;
  logic [15:0] mem_addr_b, pc_b;
  logic [31:0] mem_wdata_b, mem_rdata_b;
  logic        run_b = 1'b0;

  risc_core_mc #(.WORD_SIZE(32), .REG_COUNT(4), .ADDR_SIZE(16)) u_dut_b (
    .clk(clk), .rst(rst), .run(run_b),
    .mem_req(mem_req_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .mem_ready(mem_ready_b),
    .halted(halted_b), .illegal(illegal_b), .pc_out(pc_b)
  );

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory model A (wait states) ----------------
  logic [15:0] mem_a [256];
  int          wait_cfg   = 0;
  int          wcnt       = 0;
  int          wr_count   = 0;
  int          wr_extra   = 0;
  int          stable_err = 0;
  int          req_cnt    = 0;
  logic [15:0] held_addr, held_wdata;
  logic        held_we;
  logic        same_held;

  assign mem_ready_a = mem_req_a && (wcnt >= wait_cfg);
  assign mem_rdata_a = mem_a[mem_addr_a[7:0]];
  assign same_held   = (held_addr == mem_addr_a) && (held_we == mem_we_a) &&
                       (held_wdata == mem_wdata_a);

  always @(posedge clk) begin
    if (mem_req_a) req_cnt <= req_cnt + 1;
    if (!mem_req_a) begin
      wcnt <= 0;
    end else if (mem_ready_a) begin
      wcnt <= 0;
      if (wcnt > 0 && !same_held) stable_err <= stable_err + 1;
      if (mem_we_a) begin
        mem_a[mem_addr_a[7:0]] <= mem_wdata_a;
        wr_count <= wr_count + 1;
        if (exp_q.size() > 0) check_val("wr_data", {16'h0, mem_wdata_a}, exp_q.pop_front());
        else wr_extra <= wr_extra + 1;
      end
    end else begin
      wcnt <= wcnt + 1;
      if (wcnt > 0 && !same_held) stable_err <= stable_err + 1;
    end
    held_addr  <= mem_addr_a;
    held_we    <= mem_we_a;
    held_wdata <= mem_wdata_a;
  end

  // ---------------- memory model B (zero wait) ----------------
  logic [31:0] mem_b [256];
  assign mem_ready_b = mem_req_b;
  assign mem_rdata_b = mem_b[mem_addr_b[7:0]];

  always @(posedge clk) begin
    if (mem_req_b && mem_we_b) mem_b[mem_addr_b[7:0]] <= mem_wdata_b;
  end

  // ---------------- driver helpers ----------------
  function automatic logic [15:0] ia(input logic [3:0] op, input int s, input int d);
    return {op, 3'(s), 3'(d), 6'b0};
  endfunction

  function automatic logic [31:0] ib(input logic [3:0] op, input int s, input int d);
    return {op, 2'(s), 2'(d), 24'b0};
  endfunction

  task automatic prep();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) mem_a[i] = 16'h0;
    wait_cfg   = 0;
    wr_count   = 0;
    wr_extra   = 0;
    stable_err = 0;
    exp_q.delete();
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_until_halt(input string tag);
    int n = 0;
    while (!halted_a && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, {31'h0, halted_a}, 32'h1);
  endtask

  task automatic check_writes(input string tag);
    check_val({tag, "_wr_extra"}, wr_extra, 0);
    check_val({tag, "_wr_pending"}, exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem_b[i] = 32'h0;
    mem_b[8'h00] = ib(OP_RD, 0, 1);   mem_b[8'h01] = 32'h20;
    mem_b[8'h02] = ib(OP_RD, 0, 2);   mem_b[8'h03] = 32'h21;
    mem_b[8'h04] = ib(OP_ADD, 2, 1);
    mem_b[8'h05] = ib(4'hF, 1, 1);
    mem_b[8'h06] = ib(OP_BRZ, 0, 0);  mem_b[8'h07] = 32'h40;
    mem_b[8'h08] = ib(OP_HALT, 0, 0);
    mem_b[8'h20] = 32'hFFFF_FFFF;     mem_b[8'h21] = 32'h1;
    mem_b[8'h30] = 32'hAAAA_AAAA;
    mem_b[8'h40] = ib(OP_WR, 1, 0);   mem_b[8'h41] = 32'h30;
    mem_b[8'h42] = ib(OP_HALT, 0, 0);

    // Reset values
    prep();
    #1;
    check_val("rst_req",     {31'h0, mem_req_a}, 32'h0);
    check_val("rst_we",      {31'h0, mem_we_a},  32'h0);
    check_val("rst_addr",    {16'h0, mem_addr_a}, 32'h0);
    check_val("rst_pc",      {16'h0, pc_a},      32'h0);
    check_val("rst_halted",  {31'h0, halted_a},  32'h0);
    check_val("rst_illegal", {31'h0, illegal_a}, 32'h0);

    // Test 1: reset mid-RD drops the request at once; refetch from 0
    mem_a[0] = ia(OP_RD, 0, 1); mem_a[1] = 16'h20; mem_a[2] = ia(OP_HALT, 0, 0);
    mem_a[8'h20] = 16'h5555;
    wait_cfg = 5;
    release_rst();
    n = 0;
    while (!(mem_req_a && !mem_we_a && mem_addr_a == 16'h20) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("t1_rd_reached", {16'h0, mem_addr_a}, 32'h20);
    #2 rst = 1'b0;
    #1;
    check_val("t1_req_drop", {31'h0, mem_req_a}, 32'h0);
    check_val("t1_pc_clear", {16'h0, pc_a}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    while (!mem_req_a && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_val("t1_refetch_req",  {31'h0, mem_req_a}, 32'h1);
    check_val("t1_refetch_addr", {16'h0, mem_addr_a}, 32'h0);
    run_until_halt("t1_halt");

    // Test 2: RD/RD/ADD -> 0x8000, Z=0 so BRZ falls through
    prep();
    mem_a[0] = ia(OP_RD, 0, 1);   mem_a[1] = 16'h20;
    mem_a[2] = ia(OP_RD, 0, 2);   mem_a[3] = 16'h21;
    mem_a[4] = ia(OP_ADD, 2, 1);
    mem_a[5] = ia(OP_WR, 1, 0);   mem_a[6] = 16'h30;
    mem_a[7] = ia(OP_BRZ, 0, 0);  mem_a[8] = 16'h50;
    mem_a[9] = ia(OP_HALT, 0, 0);
    mem_a[8'h20] = 16'h7FFF; mem_a[8'h21] = 16'h0001; mem_a[8'h50] = ia(OP_HALT, 0, 0);
    exp_q.push_back(32'h8000);
    release_rst();
    run_until_halt("t2_halt");
    check_val("t2_mem30", {16'h0, mem_a[8'h30]}, 32'h8000);
    check_val("t2_pc_not_taken", {16'h0, pc_a}, 32'h000A);
    check_writes("t2");

    // Test 3: SUB R3,R3 -> 0, Z=1 so BRZ is taken
    prep();
    mem_a[0] = ia(OP_RD, 0, 3);   mem_a[1] = 16'h22;
    mem_a[2] = ia(OP_SUB, 3, 3);
    mem_a[3] = ia(OP_WR, 3, 0);   mem_a[4] = 16'h31;
    mem_a[5] = ia(OP_BRZ, 0, 0);  mem_a[6] = 16'h40;
    mem_a[7] = ia(OP_HALT, 0, 0);
    mem_a[8'h22] = 16'h1234; mem_a[8'h31] = 16'hFFFF; mem_a[8'h40] = ia(OP_HALT, 0, 0);
    exp_q.push_back(32'h0);
    release_rst();
    run_until_halt("t3_halt");
    check_val("t3_mem31", {16'h0, mem_a[8'h31]}, 32'h0);
    check_val("t3_pc_taken", {16'h0, pc_a}, 32'h0041);
    check_writes("t3");

    // Test 4: three wait states on every access
    prep();
    mem_a[0] = ia(OP_RD, 0, 1);   mem_a[1] = 16'h20;
    mem_a[2] = ia(OP_WR, 1, 0);   mem_a[3] = 16'h30;
    mem_a[4] = ia(OP_HALT, 0, 0);
    mem_a[8'h20] = 16'h1234;
    wait_cfg = 3;
    exp_q.push_back(32'h1234);
    release_rst();
    run_until_halt("t4_halt");
    check_val("t4_mem30", {16'h0, mem_a[8'h30]}, 32'h1234);
    check_val("t4_wr_count", wr_count, 1);
    check_val("t4_stable", stable_err, 0);
    check_val("t4_pc", {16'h0, pc_a}, 32'h0005);
    check_writes("t4");

    // Test 5: HALT is quiet; run resumes at HALT address + 1
    prep();
    mem_a[0] = ia(OP_HALT, 0, 0);
    mem_a[1] = ia(OP_NOT, 0, 4);
    mem_a[2] = ia(OP_WR, 4, 0);   mem_a[3] = 16'h32;
    mem_a[4] = ia(OP_HALT, 0, 0);
    exp_q.push_back(32'hFFFF);
    release_rst();
    run_until_halt("t5_halt1");
    check_val("t5_pc_halt", {16'h0, pc_a}, 32'h0001);
    @(negedge clk);
    req_cnt = 0;
    repeat (20) @(negedge clk);
    check_val("t5_quiet", req_cnt, 0);
    check_val("t5_still_halted", {31'h0, halted_a}, 32'h1);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    check_val("t5_resume_req",  {31'h0, mem_req_a}, 32'h1);
    check_val("t5_resume_addr", {16'h0, mem_addr_a}, 32'h0001);
    check_val("t5_unhalted",    {31'h0, halted_a}, 32'h0);
    run_until_halt("t5_halt2");
    check_val("t5_mem32", {16'h0, mem_a[8'h32]}, 32'hFFFF);
    check_val("t5_pc_end", {16'h0, pc_a}, 32'h0005);
    check_writes("t5");

    // Test 6: illegal opcode is sticky and behaves as NOP
    prep();
    mem_a[0] = ia(OP_RD, 0, 1);   mem_a[1] = 16'h20;
    mem_a[2] = ia(4'hF, 1, 1);
    mem_a[3] = ia(OP_WR, 1, 0);   mem_a[4] = 16'h33;
    mem_a[5] = ia(OP_HALT, 0, 0);
    mem_a[8'h20] = 16'h7FFF;
    exp_q.push_back(32'h7FFF);
    release_rst();
    check_val("t6_illegal_clear", {31'h0, illegal_a}, 32'h0);
    run_until_halt("t6_halt");
    check_val("t6_illegal", {31'h0, illegal_a}, 32'h1);
    check_val("t6_mem33", {16'h0, mem_a[8'h33]}, 32'h7FFF);
    check_val("t6_pc", {16'h0, pc_a}, 32'h0006);
    check_writes("t6");

    // 32-bit / 4-register core: wrap to zero, Z kept through illegal, branch taken
    repeat (60) @(negedge clk);
    check_val("b_halted",  {31'h0, halted_b},  32'h1);
    check_val("b_illegal", {31'h0, illegal_b}, 32'h1);
    check_val("b_pc",      {16'h0, pc_b},      32'h0043);
    check_val("b_mem30",   mem_b[8'h30],       32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
